// File: rtl/proj_pkg.sv
// Shared types and default sizing for the bottom-K MinHash selector.
//   HASHER_EXTENDER_INDICES_COUNT : entries kept per set (default K)
//   HASHER_SORTER_SIGNATURE       : signature width (default SIG_W)
//   SORTER_INDICE_LEN             : element index width (default IDX_W)
//   sorter_entry_t                : one slot {occ, signature, index} at default widths
//   sorter_state_e                : selector FSM states
package proj_pkg;

  localparam int HASHER_EXTENDER_INDICES_COUNT = 16;
  localparam int HASHER_SORTER_SIGNATURE       = 32;
  localparam int SORTER_INDICE_LEN             = 8;

  typedef struct packed {
    logic                               occ;
    logic [HASHER_SORTER_SIGNATURE-1:0] signature;
    logic [SORTER_INDICE_LEN-1:0]       index;
  } sorter_entry_t;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } sorter_state_e;

endpackage

// File: rtl/proj_sorter_cell.sv
// One slot of the sorted entry array.
// Holds {occ, signature, index} and decides its own next value from the
// incoming beat and its neighbours:
//   clk, rst_n         : clock, asynchronous active-low reset
//   ins_en_i           : a beat is being inserted into the array this cycle
//   shift_dn_i         : drain handshake, take the upper neighbour's entry
//   clr_i              : end of set, drop occupancy
//   new_sig_i/new_idx_i: incoming beat
//   lower_*_i          : slot below (index i-1); lower_gt_i=0 for slot 0
//   upper_*_i          : slot above (index i+1); unoccupied for slot K-1
//   gt_o               : this slot is free or holds a larger signature
//   match_o            : this slot is occupied with an equal signature
//   occ_o/sig_o/idx_o  : current slot contents
module proj_sorter_cell #(
  parameter int SIG_W = 32,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ins_en_i,
  input  logic             shift_dn_i,
  input  logic             clr_i,
  input  logic [SIG_W-1:0] new_sig_i,
  input  logic [IDX_W-1:0] new_idx_i,
  input  logic             lower_gt_i,
  input  logic             lower_occ_i,
  input  logic [SIG_W-1:0] lower_sig_i,
  input  logic [IDX_W-1:0] lower_idx_i,
  input  logic             upper_occ_i,
  input  logic [SIG_W-1:0] upper_sig_i,
  input  logic [IDX_W-1:0] upper_idx_i,
  output logic             gt_o,
  output logic             match_o,
  output logic             occ_o,
  output logic [SIG_W-1:0] sig_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             occ_q, occ_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             insert_here;
  logic             shift_up;

  // Strict '>' keeps an existing equal entry ahead of the new beat. Because
  // the array is sorted with occupied slots contiguous, gt is monotonic in
  // slot index: false below the insert point, true from it upward.
  assign gt_o    = !occ_q || (sig_q > new_sig_i);
  assign match_o = occ_q && (sig_q == new_sig_i);

  // The first slot whose gt is set takes the beat; every slot above it
  // inherits its lower neighbour's entry.
  assign insert_here = ins_en_i && gt_o && !lower_gt_i;
  assign shift_up    = ins_en_i && lower_gt_i;

  always_comb begin
    occ_d = occ_q;
    sig_d = sig_q;
    idx_d = idx_q;
    if (clr_i) begin
      occ_d = 1'b0;
    end else if (shift_dn_i) begin
      occ_d = upper_occ_i;
      sig_d = upper_sig_i;
      idx_d = upper_idx_i;
    end else if (shift_up) begin
      occ_d = lower_occ_i;
      sig_d = lower_sig_i;
      idx_d = lower_idx_i;
    end else if (insert_here) begin
      occ_d = 1'b1;
      sig_d = new_sig_i;
      idx_d = new_idx_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= 1'b0;
      sig_q <= '0;
      idx_q <= '0;
    end else begin
      occ_q <= occ_d;
      sig_q <= sig_d;
      idx_q <= idx_d;
    end
  end

  assign occ_o = occ_q;
  assign sig_o = sig_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/proj_bottomk_stream_sorter.sv
// Streaming bottom-K MinHash selector.
// Accepts (signature, index) beats, keeps the K smallest signatures of the
// current set in ascending order and, after the set's last beat, drains them
// smallest-first over a back-pressured output port.
//   in_clk, in_rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready         : input handshake (ready only while accumulating)
//   in_signature/index/last   : input beat, in_last marks the end of the set
//   out_valid/out_ready       : output handshake (valid only while draining)
//   out_signature/index/last  : smallest remaining entry, out_last on the final one
//   out_count                 : entries still held while draining, 0 otherwise
module proj_bottomk_stream_sorter
  import proj_pkg::*;
#(
  parameter int K     = HASHER_EXTENDER_INDICES_COUNT,
  parameter int SIG_W = HASHER_SORTER_SIGNATURE,
  parameter int IDX_W = SORTER_INDICE_LEN,
  parameter int DEDUP = 1
) (
  input  logic                     in_clk,
  input  logic                     in_rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIG_W-1:0]         in_signature,
  input  logic [IDX_W-1:0]         in_index,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIG_W-1:0]         out_signature,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_last,
  output logic [$clog2(K+1)-1:0]   out_count
);

  localparam int CW = $clog2(K+1);

  sorter_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  logic [K-1:0]     gt;
  logic [K-1:0]     match;
  logic [K-1:0]     occ;
  logic [SIG_W-1:0] sig [K];
  logic [IDX_W-1:0] idx [K];

  logic [K-1:0]     lower_gt;
  logic [K-1:0]     lower_occ;
  logic [SIG_W-1:0] lower_sig [K];
  logic [IDX_W-1:0] lower_idx [K];
  logic [K-1:0]     upper_occ;
  logic [SIG_W-1:0] upper_sig [K];
  logic [IDX_W-1:0] upper_idx [K];

  logic in_fire;
  logic out_fire;
  logic dup_drop;
  logic ins_en;
  logic drain_done;

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign dup_drop   = (DEDUP != 0) && (|match);
  assign ins_en     = in_fire && !dup_drop;
  assign drain_done = out_fire && out_last;

  // ---------------------------------------------------------------- slots
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_slot
      if (gi == 0) begin : g_bottom
        assign lower_gt[gi]  = 1'b0;
        assign lower_occ[gi] = 1'b0;
        assign lower_sig[gi] = '0;
        assign lower_idx[gi] = '0;
      end else begin : g_lower
        assign lower_gt[gi]  = gt[gi-1];
        assign lower_occ[gi] = occ[gi-1];
        assign lower_sig[gi] = sig[gi-1];
        assign lower_idx[gi] = idx[gi-1];
      end

      // The top slot refills with an empty entry when the array drains down.
      if (gi == K-1) begin : g_top
        assign upper_occ[gi] = 1'b0;
        assign upper_sig[gi] = '0;
        assign upper_idx[gi] = '0;
      end else begin : g_upper
        assign upper_occ[gi] = occ[gi+1];
        assign upper_sig[gi] = sig[gi+1];
        assign upper_idx[gi] = idx[gi+1];
      end

      proj_sorter_cell #(
        .SIG_W (SIG_W),
        .IDX_W (IDX_W)
      ) u_cell (
        .clk         (in_clk),
        .rst_n       (in_rst_n),
        .ins_en_i    (ins_en),
        .shift_dn_i  (out_fire),
        .clr_i       (drain_done),
        .new_sig_i   (in_signature),
        .new_idx_i   (in_index),
        .lower_gt_i  (lower_gt[gi]),
        .lower_occ_i (lower_occ[gi]),
        .lower_sig_i (lower_sig[gi]),
        .lower_idx_i (lower_idx[gi]),
        .upper_occ_i (upper_occ[gi]),
        .upper_sig_i (upper_sig[gi]),
        .upper_idx_i (upper_idx[gi]),
        .gt_o        (gt[gi]),
        .match_o     (match[gi]),
        .occ_o       (occ[gi]),
        .sig_o       (sig[gi]),
        .idx_o       (idx[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------- count
  // gt of the top slot is set exactly when the beat lands somewhere in the
  // array; a full array stays full because slot K-1 is discarded.
  always_comb begin
    count_d = count_q;
    if (drain_done) begin
      count_d = '0;
    end else if (out_fire) begin
      count_d = count_q - CW'(1);
    end else if (ins_en && gt[K-1] && (count_q != CW'(K))) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (in_fire && in_last) state_d = DRAIN;
      DRAIN:   if (drain_done)         state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Outputs decode only from state and slot registers; the data fields are
  // forced to zero outside DRAIN so nothing leaks while accumulating.
  always_comb begin
    in_ready      = (state_q == ACCUM);
    out_valid     = (state_q == DRAIN);
    out_last      = 1'b0;
    out_count     = '0;
    out_signature = '0;
    out_index     = '0;
    if (state_q == DRAIN) begin
      out_last      = (count_q == CW'(1));
      out_count     = count_q;
      out_signature = sig[0];
      out_index     = idx[0];
    end
  end

endmodule

// File: tb/tb_proj_bottomk_stream_sorter.sv
// Directed bench for proj_bottomk_stream_sorter with K=4.
// Two instances share data inputs: index 0 has DEDUP=1, index 1 has DEDUP=0.
// A table of sets with hand-computed drained output is run in a loop, then
// hand-written sequences cover output stalls and asynchronous reset.
module tb_proj_bottomk_stream_sorter;
  import proj_pkg::*;

  localparam int K     = 4;
  localparam int SIG_W = 32;
  localparam int IDX_W = 8;
  localparam int CW    = $clog2(K+1);

  logic in_clk   = 1'b0;
  logic in_rst_n = 1'b1;
  always #5 in_clk = ~in_clk;

  logic [1:0]       in_valid_v  = '0;
  logic [1:0]       out_ready_v = '0;
  logic [1:0]       in_ready_v;
  logic [1:0]       out_valid_v;
  logic [1:0]       out_last_v;
  logic [SIG_W-1:0] in_signature = '0;
  logic [IDX_W-1:0] in_index     = '0;
  logic             in_last      = 1'b0;
  logic [SIG_W-1:0] out_sig_v [2];
  logic [IDX_W-1:0] out_idx_v [2];
  logic [CW-1:0]    out_cnt_v [2];

  proj_bottomk_stream_sorter #(.K(K), .SIG_W(SIG_W), .IDX_W(IDX_W), .DEDUP(1)) dut_dedup (
    .in_clk(in_clk), .in_rst_n(in_rst_n),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_signature(in_signature), .in_index(in_index), .in_last(in_last),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_signature(out_sig_v[0]), .out_index(out_idx_v[0]),
    .out_last(out_last_v[0]), .out_count(out_cnt_v[0])
  );

  proj_bottomk_stream_sorter #(.K(K), .SIG_W(SIG_W), .IDX_W(IDX_W), .DEDUP(0)) dut_keep (
    .in_clk(in_clk), .in_rst_n(in_rst_n),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_signature(in_signature), .in_index(in_index), .in_last(in_last),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_signature(out_sig_v[1]), .out_index(out_idx_v[1]),
    .out_last(out_last_v[1]), .out_count(out_cnt_v[1])
  );

  typedef struct {
    int                     which;
    int                     n_in;
    logic [7:0][SIG_W-1:0]  in_sig;
    int                     n_out;
    sorter_entry_t [7:0]    exp;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic in_beat(input int v, input logic [SIG_W-1:0] s);
    vecs[v].in_sig[vecs[v].n_in] = s;
    vecs[v].n_in++;
  endtask

  task automatic exp_out(input int v, input logic [SIG_W-1:0] s, input logic [IDX_W-1:0] i);
    vecs[v].exp[vecs[v].n_out] = '{occ: 1'b1, signature: s, index: i};
    vecs[v].n_out++;
  endtask

  // Feeds every beat of a set; returns at the negedge after the last beat.
  task automatic send_set(input int v);
    int w;
    w = vecs[v].which;
    for (int b = 0; b < vecs[v].n_in; b++) begin
      @(negedge in_clk);
      check($sformatf("v%0d in_ready beat%0d", v, b), 32'(in_ready_v[w]), 32'd1);
      in_valid_v[w] = 1'b1;
      in_signature  = vecs[v].in_sig[b];
      in_index      = IDX_W'(b);
      in_last       = (b == vecs[v].n_in - 1);
      @(posedge in_clk);
    end
    @(negedge in_clk);
    in_valid_v[w] = 1'b0;
    in_last       = 1'b0;
    check($sformatf("v%0d out_valid after last", v), 32'(out_valid_v[w]), 32'd1);
    check($sformatf("v%0d in_ready in drain", v), 32'(in_ready_v[w]), 32'd0);
  endtask

  // Drains with out_ready held high; starts and ends at a negedge.
  task automatic drain_set(input int v);
    int w;
    w = vecs[v].which;
    for (int j = 0; j < vecs[v].n_out; j++) begin
      check($sformatf("v%0d out%0d valid", v, j), 32'(out_valid_v[w]), 32'd1);
      check($sformatf("v%0d out%0d sig", v, j), out_sig_v[w], vecs[v].exp[j].signature);
      check($sformatf("v%0d out%0d idx", v, j), 32'(out_idx_v[w]), 32'(vecs[v].exp[j].index));
      check($sformatf("v%0d out%0d last", v, j), 32'(out_last_v[w]), 32'(j == vecs[v].n_out - 1));
      check($sformatf("v%0d out%0d count", v, j), 32'(out_cnt_v[w]), 32'(vecs[v].n_out - j));
      out_ready_v[w] = 1'b1;
      @(posedge in_clk);
      @(negedge in_clk);
    end
    out_ready_v[w] = 1'b0;
    check($sformatf("v%0d out_valid after drain", v), 32'(out_valid_v[w]), 32'd0);
    check($sformatf("v%0d in_ready after drain", v), 32'(in_ready_v[w]), 32'd1);
    check($sformatf("v%0d out_count after drain", v), 32'(out_cnt_v[w]), 32'd0);
    $display("set %0d on dut %0d: %0d beats in, %0d entries drained", v, w, vecs[v].n_in, vecs[v].n_out);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int w = 0; w < 2; w++) begin
      check($sformatf("%s dut%0d in_ready", tag, w), 32'(in_ready_v[w]), 32'd1);
      check($sformatf("%s dut%0d out_valid", tag, w), 32'(out_valid_v[w]), 32'd0);
      check($sformatf("%s dut%0d out_last", tag, w), 32'(out_last_v[w]), 32'd0);
      check($sformatf("%s dut%0d out_count", tag, w), 32'(out_cnt_v[w]), 32'd0);
      check($sformatf("%s dut%0d out_sig", tag, w), out_sig_v[w], 32'd0);
      check($sformatf("%s dut%0d out_idx", tag, w), 32'(out_idx_v[w]), 32'd0);
    end
  endtask

  initial begin
    logic [11:0] pat;
    int          j;

    for (int v = 0; v < NV; v++) begin
      vecs[v].which = 0; vecs[v].n_in = 0; vecs[v].n_out = 0;
      vecs[v].in_sig = '0; vecs[v].exp = '0;
    end
    // 0: basic ordering
    in_beat(0, 50); in_beat(0, 10); in_beat(0, 40); in_beat(0, 30); in_beat(0, 20);
    exp_out(0, 10, 1); exp_out(0, 20, 4); exp_out(0, 30, 3); exp_out(0, 40, 2);
    // 1: duplicate dropped
    in_beat(1, 7); in_beat(1, 7); in_beat(1, 3);
    exp_out(1, 3, 2); exp_out(1, 7, 0);
    // 2: duplicate kept, tie order preserved
    vecs[2].which = 1;
    in_beat(2, 7); in_beat(2, 7); in_beat(2, 3);
    exp_out(2, 3, 2); exp_out(2, 7, 0); exp_out(2, 7, 1);
    // 3: all-ones signature is a real value
    in_beat(3, 32'hFFFF_FFFF);
    exp_out(3, 32'hFFFF_FFFF, 0);
    // 4: overflow evicts the largest, oversize beat dropped, count saturates
    in_beat(4, 9); in_beat(4, 8); in_beat(4, 7); in_beat(4, 6); in_beat(4, 5); in_beat(4, 100);
    exp_out(4, 5, 4); exp_out(4, 6, 3); exp_out(4, 7, 2); exp_out(4, 8, 1);
    // 5: full array, tie with the largest entry lands past the end
    vecs[5].which = 1;
    in_beat(5, 1); in_beat(5, 2); in_beat(5, 3); in_beat(5, 4); in_beat(5, 4);
    exp_out(5, 1, 0); exp_out(5, 2, 1); exp_out(5, 3, 2); exp_out(5, 4, 3);
    // 6: duplicate all-ones dropped, zero sorts first
    in_beat(6, 32'hFFFF_FFFF); in_beat(6, 32'hFFFF_FFFF); in_beat(6, 0);
    exp_out(6, 0, 2); exp_out(6, 32'hFFFF_FFFF, 0);
    // 7: stalled drain
    in_beat(7, 3); in_beat(7, 1); in_beat(7, 2);
    exp_out(7, 1, 1); exp_out(7, 2, 2); exp_out(7, 3, 0);
    // 8: short set after a reset
    in_beat(8, 42); in_beat(8, 41);
    exp_out(8, 41, 1); exp_out(8, 42, 0);

    #1 in_rst_n = 1'b0;
    #2 check_reset_outputs("por");
    repeat (2) @(negedge in_clk);
    in_rst_n = 1'b1;

    for (int v = 0; v <= 6; v++) begin
      send_set(v);
      drain_set(v);
    end

    // Stalled drain: out_ready pattern 1,0,0,1,0,1 by cycle.
    send_set(7);
    pat = 12'b0000_0010_1001;
    j = 0;
    for (int c = 0; c < 12 && j < 3; c++) begin
      check($sformatf("stall c%0d valid", c), 32'(out_valid_v[0]), 32'd1);
      check($sformatf("stall c%0d sig", c), out_sig_v[0], vecs[7].exp[j].signature);
      check($sformatf("stall c%0d idx", c), 32'(out_idx_v[0]), 32'(vecs[7].exp[j].index));
      check($sformatf("stall c%0d in_ready", c), 32'(in_ready_v[0]), 32'd0);
      out_ready_v[0] = pat[c];
      @(posedge in_clk);
      if (pat[c]) j++;
      @(negedge in_clk);
    end
    out_ready_v[0] = 1'b0;
    check("stall entries drained", 32'(j), 32'd3);
    check("stall in_ready after last", 32'(in_ready_v[0]), 32'd1);
    check("stall out_valid after last", 32'(out_valid_v[0]), 32'd0);
    $display("stalled drain: %0d entries", j);

    // Reset in the middle of accumulating a set.
    @(negedge in_clk);
    in_valid_v[0] = 1'b1; in_signature = 77; in_index = 0; in_last = 1'b0;
    @(posedge in_clk);
    @(negedge in_clk);
    in_signature = 66; in_index = 1;
    @(posedge in_clk);
    #2 in_valid_v[0] = 1'b0;
    in_rst_n = 1'b0;
    #1 check_reset_outputs("rst mid-set");
    @(negedge in_clk);
    in_rst_n = 1'b1;
    send_set(8);
    drain_set(8);

    // Reset in the middle of draining a set.
    vecs[3].in_sig[0] = 5;
    send_set(3);
    out_ready_v[0] = 1'b1;
    @(posedge in_clk);
    #2 in_rst_n = 1'b0;
    #1 check_reset_outputs("rst mid-drain");
    @(negedge in_clk);
    out_ready_v[0] = 1'b0;
    in_rst_n = 1'b1;
    send_set(8);
    drain_set(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
